// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, reset vector, instruction field layout
// and the register-select codes used by the executor.
package cpu_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 11;
  localparam int REG_MSB = 10;
  localparam int REG_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    REG_NONE = 3'd0,
    REG_R0   = 3'd1,
    REG_BP   = 3'd2,
    REG_SP   = 3'd3,
    REG_R1   = 3'd4
  } reg_sel_e;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_e;

  function automatic logic [4:0] instrOpcode(input logic [15:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Instruction queue: synchronous FIFO with flush and a registered copy of the
// head entry so the consumer sees a flop output rather than a memory read.
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [PW-1:0] PTR_MASK = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [PW-1:0]    rdNext;
  logic             doPop;

  always_comb begin
    doPop   = pop_i && (count_q != '0);
    rdNext  = (rdPtr_q + PW'(1)) & PTR_MASK;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      head_d  = '0;
    end else begin
      if (push_i) wrPtr_d = (wrPtr_q + PW'(1)) & PTR_MASK;
      if (doPop)  rdPtr_d = rdNext;
      count_d = count_q + CW'(push_i) - CW'(doPop);
      // Head reloads from the next stored entry, or straight from the write
      // port when that entry is being written on this same edge.
      if (doPop) begin
        if (count_q >= CW'(2)) head_d = mem[rdNext];
        else if (push_i)       head_d = wdata_i;
      end else if (push_i && (count_q == '0)) begin
        head_d = wdata_i;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem[wrPtr_q] <= wdata_i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: streams sequential ROM words into a small queue tagged
// with their PC, throttled by queue credit, and flushed by redirects.
module instr_prefetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  output logic          ins_valid,
  output logic [DW-1:0] ins_data,
  output logic [AW-1:0] ins_pc,
  input  logic          ins_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [CW-1:0] o_count,
  output logic [AW-1:0] o_fetch_pc
);

  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fetchPc_q, fetchPc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflightPc_q, inflightPc_d;
  logic [AW-1:0] issuePc;
  logic          issue;
  logic          pop;
  logic          creditOk;
  logic [CW:0]   occAfter;
  logic [CW-1:0] count;
  logic [DW+AW-1:0] head;

  // Credit counts the word already in flight, so a capture can never land
  // on a full queue.
  always_comb begin
    pop          = ins_valid && ins_ready;
    occAfter     = (CW + 1)'(count) + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    creditOk     = occAfter < DEPTH_V;
    state_d      = state_q;
    issue        = 1'b0;
    issuePc      = fetchPc_q;
    fetchPc_d    = fetchPc_q;
    inflight_d   = 1'b0;
    inflightPc_d = inflightPc_q;
    if (redirect) begin
      issue   = 1'b1;
      issuePc = redirect_pc;
      state_d = FETCH_RUN;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (creditOk) issue = 1'b1;
          else          state_d = FETCH_HOLD;
        end
        FETCH_HOLD: begin
          if (pop && creditOk) begin
            issue   = 1'b1;
            state_d = FETCH_RUN;
          end
        end
        default: state_d = FETCH_RUN;
      endcase
    end
    if (issue) begin
      fetchPc_d    = issuePc + AW'(1);
      inflight_d   = 1'b1;
      inflightPc_d = issuePc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH_RUN;
      fetchPc_q    <= AW'(RESET_PC);
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
    end else begin
      state_q      <= state_d;
      fetchPc_q    <= fetchPc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
    end
  end

  ifq_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DW + AW)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (inflight_q && !redirect),
    .pop_i  (pop && !redirect),
    .flush_i(redirect),
    .wdata_i({rom_q, inflightPc_q}),
    .head_o (head),
    .count_o(count)
  );

  assign rom_addr   = issuePc;
  assign ins_valid  = (count != '0);
  assign ins_data   = head[DW+AW-1:AW];
  assign ins_pc     = head[AW-1:0];
  assign o_count    = count;
  assign o_fetch_pc = fetchPc_q;

endmodule
